// File: rtl/somador_serial4_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: state encoding and default width.
package somador_serial4_pkg;

  localparam int unsigned DefaultWidth = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAdd  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/somador_serial4_if.sv
// Operand/result bundle between the serial adder and its user; vectors use index 0 = MSB.
interface somador_serial4_if
  import somador_serial4_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
);
  logic             start;
  logic             sub;
  logic             cin;
  logic [0:WIDTH-1] A;
  logic [0:WIDTH-1] B;
  logic [0:WIDTH-1] S;
  logic             cout;
  logic             ovf;
  logic             busy;
  logic             done;

  modport master (
    output start, sub, cin, A, B,
    input  S, cout, ovf, busy, done
  );

  modport slave (
    input  start, sub, cin, A, B,
    output S, cout, ovf, busy, done
  );
endinterface

// File: rtl/somador1.sv
// Combinational 1-bit full adder.
module somador1 (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/somador_serial4.sv
// Bit-serial adder/subtractor, LSB first, one bit per clock; S/cout/ovf change only when an
// operation completes so the downstream decoder never sees a partial sum.
module somador_serial4
  import somador_serial4_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input logic             clk,
  input logic             rst,
  somador_serial4_if.slave bus
);
  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  state_e           state_q;
  logic [0:WIDTH-1] a_q, b_q, r_q, r_nxt, s_q;
  logic [CntW-1:0]  cnt_q;
  logic             carry_q, cout_q, ovf_q, busy_q, done_q;
  logic             sum_bit, carry_nxt;

  // LSB lives at index WIDTH-1 of the operand shift registers.
  somador1 u_fa (
    .a (a_q[WIDTH-1]),
    .b (b_q[WIDTH-1]),
    .ci(carry_q),
    .s (sum_bit),
    .co(carry_nxt)
  );

  // Sum bits enter from the MSB side so the first (LSB) one ends at index WIDTH-1.
  always_comb begin
    r_nxt    = r_q >> 1;
    r_nxt[0] = sum_bit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q     <= bus.A;
            b_q     <= bus.sub ? ~bus.B : bus.B;
            carry_q <= bus.sub ? 1'b1 : bus.cin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StAdd;
          end
        end
        StAdd: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          r_q     <= r_nxt;
          carry_q <= carry_nxt;
          cnt_q   <= cnt_q + CntW'(1);
          if (cnt_q == LastBit) begin
            s_q     <= r_nxt;
            cout_q  <= carry_nxt;
            // carry_q here is the carry into the MSB.
            ovf_q   <= carry_q ^ carry_nxt;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.S    = s_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_somador_serial4.sv
// Directed and random checks of somador_serial4 against an integer-arithmetic reference model.
module tb_somador_serial4;
  localparam int unsigned W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  somador_serial4_if #(.WIDTH(W)) bus ();

  somador_serial4 #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [0:3] exp_s;
  logic       exp_cout;
  logic       exp_ovf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: unsigned/signed integer arithmetic, modulo 16.
  task automatic model(input logic [0:3] a, input logic [0:3] b, input logic sb, input logic ci,
                       output logic [0:3] s, output logic co, output logic ov);
    int ua, ub, sa, sbv, u, sres;
    ua  = int'(a);
    ub  = int'(b);
    sa  = a[0] ? ua - 16 : ua;
    sbv = b[0] ? ub - 16 : ub;
    if (sb) begin
      u    = (ua - ub + 16) % 16;
      co   = (ua >= ub);
      sres = sa - sbv;
    end else begin
      u    = ua + ub + (ci ? 1 : 0);
      co   = (u >= 16);
      u    = u % 16;
      sres = sa + sbv + (ci ? 1 : 0);
    end
    s  = 4'(u);
    ov = (sres > 7) || (sres < -8);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".S"}, 32'(bus.S), 32'(exp_s));
    check({tag, ".cout"}, 32'(bus.cout), 32'(exp_cout));
    check({tag, ".ovf"}, 32'(bus.ovf), 32'(exp_ovf));
  endtask

  // Start an operation and follow it through ADD, DONE and back to IDLE.
  task automatic do_op(input string tag, input logic [0:3] a, input logic [0:3] b,
                       input logic sb, input logic ci);
    @(negedge clk);
    bus.A     = a;
    bus.B     = b;
    bus.sub   = sb;
    bus.cin   = ci;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.A     = ~a;
    bus.B     = ~b;
    for (int i = 0; i < 4; i++) begin
      check({tag, ".busy"}, 32'(bus.busy), 32'd1);
      check({tag, ".done_early"}, 32'(bus.done), 32'd0);
      check({tag, ".hold"}, 32'(bus.S), 32'(exp_s));
      @(negedge clk);
    end
    model(a, b, sb, ci, exp_s, exp_cout, exp_ovf);
    check({tag, ".done"}, 32'(bus.done), 32'd1);
    check({tag, ".busy_done"}, 32'(bus.busy), 32'd0);
    check_outputs(tag);
    @(negedge clk);
    check({tag, ".done_once"}, 32'(bus.done), 32'd0);
    check({tag, ".idle_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.cin   = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    exp_s     = '0;
    exp_cout  = 1'b0;
    exp_ovf   = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs("reset");
    check("reset.busy", 32'(bus.busy), 32'd0);
    check("reset.done", 32'(bus.done), 32'd0);
    rst = 1'b0;

    // Directed cases
    do_op("add_ovf", 4'b0101, 4'b0011, 1'b0, 1'b0);
    do_op("add_cout", 4'b1111, 4'b0001, 1'b0, 1'b0);
    do_op("add_cin", 4'b0000, 4'b0000, 1'b0, 1'b1);
    do_op("sub_neg", 4'b0011, 4'b0101, 1'b1, 1'b1);
    do_op("sub_pos", 4'b0111, 4'b0010, 1'b1, 1'b0);

    // start held through ADD and DONE with different operands: must be ignored
    @(negedge clk);
    bus.A = 4'b0110; bus.B = 4'b0011; bus.sub = 1'b0; bus.cin = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.A = 4'b1001; bus.B = 4'b0111; bus.sub = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("ign.busy", 32'(bus.busy), 32'd1);
      check("ign.done_early", 32'(bus.done), 32'd0);
      @(negedge clk);
    end
    model(4'b0110, 4'b0011, 1'b0, 1'b0, exp_s, exp_cout, exp_ovf);
    check("ign.done", 32'(bus.done), 32'd1);
    check_outputs("ign");
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("ign.no_second_done", 32'(bus.done), 32'd0);
      check("ign.no_restart", 32'(bus.busy), 32'd0);
      @(negedge clk);
    end
    check_outputs("ign.after");

    // Reset in the second ADD cycle abandons the operation
    do_op("pre_rst", 4'b0101, 4'b0011, 1'b0, 1'b0);
    @(negedge clk);
    bus.A = 4'b1111; bus.B = 4'b0001; bus.sub = 1'b0; bus.cin = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("rst.S_before", 32'(bus.S), 32'(4'b1000));
    check("rst.busy_before", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    exp_s    = '0;
    exp_cout = 1'b0;
    exp_ovf  = 1'b0;
    check_outputs("rst");
    check("rst.busy", 32'(bus.busy), 32'd0);
    check("rst.done", 32'(bus.done), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rst.no_done", 32'(bus.done), 32'd0);
      check("rst.S_hold", 32'(bus.S), 32'd0);
    end
    do_op("post_rst", 4'b0010, 4'b0011, 1'b0, 1'b1);

    // start held high: back-to-back operations every 6 cycles
    @(negedge clk);
    bus.A = 4'b0001; bus.B = 4'b0001; bus.sub = 1'b0; bus.cin = 1'b0; bus.start = 1'b1;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (i % 6 == 4) begin
        exp_s    = 4'b0010;
        exp_cout = 1'b0;
        exp_ovf  = 1'b0;
      end
      check("b2b.done", 32'(bus.done), 32'(i % 6 == 4));
      check("b2b.busy", 32'(bus.busy), 32'(i % 6 < 4));
      check("b2b.S", 32'(bus.S), 32'(exp_s));
    end
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    check("b2b.stop", 32'(bus.busy), 32'd0);

    // Random operations
    for (int i = 0; i < 24; i++) begin
      do_op("rand", 4'($urandom()), 4'($urandom()), 1'($urandom()), 1'($urandom()));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
